// File: rtl/ws2812b_rx.sv
// ws2812b_rx: WS2812B single-wire receiver. Classifies high-pulse widths into bits, assembles
// 24-bit GRB words (MSB first) on a valid/ready port, flags reset gaps and protocol errors.
// Define WS2812B_RX_FORWARD_EN to add the cascaded-LED forward output `dout`.
module ws2812b_rx #(
  parameter int unsigned CLOCK_MHZ = 64,
  parameter int unsigned THRESH_NS = 600,
  parameter int unsigned MIN_H_NS  = 150,
  parameter int unsigned MAX_H_NS  = 5000,
  parameter int unsigned RES_NS    = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  output logic [23:0] data_out,
  output logic        valid,
  input  logic        ready,
  output logic        latch,
  output logic        error,
  output logic        overrun
`ifdef WS2812B_RX_FORWARD_EN
  ,
  output logic        dout
`endif
);

  localparam logic [15:0] CYC_THRESH = 16'((CLOCK_MHZ * THRESH_NS + 500) / 1000);
  localparam logic [15:0] CYC_MIN    = 16'((CLOCK_MHZ * MIN_H_NS + 500) / 1000);
  localparam logic [15:0] CYC_MAXH   = 16'((CLOCK_MHZ * MAX_H_NS + 500) / 1000);
  localparam logic [15:0] CYC_RES    = 16'((CLOCK_MHZ * RES_NS + 500) / 1000);

  typedef enum logic [1:0] {StSync, StLow, StHigh} state_e;

  logic        sync1_q, ds_q, ds_prev_q;
  logic        rise;
  state_e      state_q, state_d;
  logic [15:0] lcnt_q, lcnt_d, lcnt_inc;
  logic [15:0] hcnt_q, hcnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [22:0] shift_q, shift_d;
  logic [23:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        latch_q, latch_d;
  logic        error_q, error_d;
  logic        overrun_q, overrun_d;
  logic        frame_q, frame_d;
  logic        bit_val;

  assign rise     = ds_q & ~ds_prev_q;
  assign lcnt_inc = (lcnt_q == 16'hFFFF) ? lcnt_q : lcnt_q + 16'd1;
  assign bit_val  = (hcnt_q >= CYC_THRESH);

  always_comb begin
    state_d   = state_q;
    lcnt_d    = lcnt_q;
    hcnt_d    = hcnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    latch_d   = 1'b0;
    error_d   = 1'b0;
    overrun_d = overrun_q;
    frame_d   = frame_q;

    if (valid_q && ready) valid_d = 1'b0;

    unique case (state_q)
      StSync: begin
        if (ds_q) begin
          lcnt_d = '0;
        end else begin
          lcnt_d = lcnt_inc;
          if (lcnt_inc == CYC_RES) state_d = StLow;
        end
      end

      StLow: begin
        lcnt_d = lcnt_inc;
        if (rise) begin
          state_d = StHigh;
          hcnt_d  = 16'd1;
        end else if (lcnt_q != CYC_RES && lcnt_inc == CYC_RES) begin
          // Only the crossing counts, so a long gap is evaluated once.
          if (bit_cnt_q != 5'd0) begin
            error_d   = 1'b1;
            bit_cnt_d = '0;
            frame_d   = 1'b0;
          end else if (frame_q) begin
            latch_d = 1'b1;
            frame_d = 1'b0;
          end
        end
      end

      StHigh: begin
        if (ds_q) begin
          hcnt_d = hcnt_q + 16'd1;
          if (hcnt_q + 16'd1 >= CYC_MAXH) begin
            error_d   = 1'b1;
            bit_cnt_d = '0;
            frame_d   = 1'b0;
            lcnt_d    = '0;
            state_d   = StSync;
          end
        end else if (hcnt_q < CYC_MIN) begin
          error_d   = 1'b1;
          bit_cnt_d = '0;
          frame_d   = 1'b0;
          lcnt_d    = 16'd1;
          state_d   = StSync;
        end else begin
          shift_d = {shift_q[21:0], bit_val};
          lcnt_d  = 16'd1;
          state_d = StLow;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d = '0;
            frame_d   = 1'b1;
            if (!valid_q || ready) begin
              data_d  = {shift_q, bit_val};
              valid_d = 1'b1;
            end else begin
              // Old word is kept; the new one is dropped.
              overrun_d = 1'b1;
              error_d   = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end

      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      ds_q      <= 1'b0;
      ds_prev_q <= 1'b0;
      state_q   <= StSync;
      lcnt_q    <= '0;
      hcnt_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      latch_q   <= 1'b0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      sync1_q   <= din;
      ds_q      <= sync1_q;
      ds_prev_q <= ds_q;
      state_q   <= state_d;
      lcnt_q    <= lcnt_d;
      hcnt_q    <= hcnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      latch_q   <= latch_d;
      error_q   <= error_d;
      overrun_q <= overrun_d;
      frame_q   <= frame_d;
    end
  end

  assign data_out = data_q;
  assign valid    = valid_q;
  assign latch    = latch_q;
  assign error    = error_q;
  assign overrun  = overrun_q;

`ifdef WS2812B_RX_FORWARD_EN
  logic fwd_q, fwd_d;

  // Forwarding opens once the first word of a frame is consumed locally.
  always_comb begin
    fwd_d = fwd_q;
    if (error_d || latch_d) begin
      fwd_d = 1'b0;
    end else if (state_q == StHigh && state_d == StLow && bit_cnt_q == 5'd23) begin
      fwd_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) fwd_q <= 1'b0;
    else        fwd_q <= fwd_d;
  end

  assign dout = fwd_q & ds_q;
`endif

endmodule

// File: doc/ws2812b_rx.md
Name: ws2812b_rx

Overview:
WS2812B single-wire decoder, the receive counterpart of the team's WS2812B transmitter.
- Samples a WS2812B data line and classifies each high-pulse width as a 0 or 1 bit.
- Assembles 24-bit GRB words, MSB first, and presents them on a valid/ready output.
- Flags the end-of-frame reset gap and protocol errors.
- Used for loopback self-test of the transmitter and for daisy-chain monitoring.

Parameters:
- CLOCK_MHZ, 64, clk frequency in MHz. All cycle constants below are round(CLOCK_MHZ*ns/1000), held in 16 bits.
- THRESH_NS, 600, high width >= this decodes as '1', otherwise '0' (64 MHz: 38 cycles).
- MIN_H_NS, 150, high width below this is a glitch (64 MHz: 10 cycles).
- MAX_H_NS, 5000, high width reaching this is an error (64 MHz: 320 cycles).
- RES_NS, 50000, low time that constitutes a reset/latch gap (64 MHz: 3200 cycles).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- din  in  1  asynchronous WS2812B line
- data_out  out  24  received word, bit 23 = first bit on the wire
- valid  out  1  data_out holds an unconsumed word
- ready  in  1  consumer accepts the word when valid && ready
- latch  out  1  one-cycle pulse: reset gap seen after at least one complete word
- error  out  1  one-cycle pulse on any protocol error
- overrun  out  1  sticky; set when a word is dropped; cleared only by reset

Behaviour:
- Reset values (rst_n low at posedge clk): data_out=0, valid=0, latch=0, error=0, overrun=0, bit count=0, state=SYNC, synchronizer flops=0.
- Synchronizer: din passes through 2 flops to give ds. Edges are detected against a registered copy of ds. Widths count cycles with ds stable.
- SYNC state:
  - Low counter runs while ds=0 and clears while ds=1.
  - At CYC_RES, go to LOW. No latch pulse.
  - Power-up and any error land here, so decoding never starts mid-frame.
- LOW state:
  - Low counter increments each cycle.
  - Rising edge of ds: go to HIGH with high counter=1.
  - Low counter reaches CYC_RES with bit count != 0: pulse error, discard the partial word, clear bit count. Evaluated once per gap.
  - Low counter reaches CYC_RES with bit count == 0 and frame_active set: pulse latch, clear frame_active.
  - Low counter saturates; it never wraps.
- HIGH state:
  - High counter increments while ds=1.
  - High counter reaches CYC_MAXH: pulse error, clear bit count, go to SYNC.
  - Falling edge with width W < CYC_MIN: pulse error, clear bit count, go to SYNC.
  - Falling edge otherwise: shift in bit (W >= CYC_THRESH), increment bit count, go to LOW with low counter=1.
- Word completion (24th bit shifted):
  - Bit count returns to 0 and frame_active is set.
  - If the output register is free, or is being consumed this same cycle (valid && ready), load data_out and set valid.
  - Otherwise drop the new word, set overrun, pulse error. The old word is preserved.
- Output handshake:
  - valid is set on the clk edge where the falling edge of the 24th bit is seen on ds, i.e. 3 clk after the din fall.
  - valid clears on a cycle with valid && ready unless a new word loads that same cycle.
  - data_out is stable while valid=1.
- latch and error never assert in the same cycle. Errors take precedence and latch is suppressed.
- Reset mid-word: all state is lost and the block re-enters SYNC.

Optional Feature:
Macro WS2812B_RX_FORWARD_EN.
- Defined: adds port dout (out, 1) that behaves like a cascaded LED.
  - dout=0 while the first word of a frame is being received.
  - After the first word completes, dout = ds until the next latch or error, then 0 again.
  - dout resets to 0.
- Undefined: no dout port and no forward logic.

Test Plan:
- Power-up, din=0 for 3200+ cycles, then word 0xA5C30F sent with 26-cycle high '0' and 51-cycle high '1' pulses (transmitter timing, 80-cycle bit period), ready=1 -> valid for 1 cycle with data_out=0xA5C30F; then a 3200-cycle low gap -> latch pulses once.
- Edge widths: high of 37 cycles -> '0'; 38 -> '1'; 9 -> error pulse, then no words decoded until a 3200-cycle low is seen.
- Three words 0x000001, 0x800000, 0xFFFFFF sent back to back with ready=0 -> first word held in data_out, overrun=1, two error pulses; after ready=1 -> 0x000001 delivered.
- 12 bits sent, then a 3200-cycle low -> error pulse, no latch, no valid; the next full word decodes correctly.
- High held for 320 cycles -> error pulse at cycle 320, back in SYNC. Separately, rst_n asserted mid-word -> all outputs 0.
- With WS2812B_RX_FORWARD_EN, two words 0x111111 and 0x222222 sent -> dout stays low during the first word and replicates the second word's pulses delayed by 2 clk; first word appears on data_out.
